uart_sha256_top: RTL and testbench



---
 rtl/uart_sha256_top.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_uart_sha256_top.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sha256_top.sv
// UART-to-SHA-256 bridge: receives a 64-byte block over 8N1 UART, runs one
// SHA-256 compression, then sends the 32-byte digest back on the TX line.

module sha256 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] text_i,
  input  logic [2:0]  cmd_i,
  input  logic        cmd_w_i,
  output logic [31:0] text_o,
  output logic [3:0]  cmd_o
);
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [31:0] w [16];
  logic [31:0] v [8];
  logic [31:0] dig [8];
  logic [6:0]  round;
  logic        busy;
  logic [3:0]  wptr;
  logic [2:0]  rptr;
  logic [31:0] new_w, t1, t2;

  assign cmd_o = {busy, 3'b000};

  // w[0] is always W_t; the window slides one word per round.
  always_comb begin
    new_w = (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10)) + w[9]
          + (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3)) + w[0];
    t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
       + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[round[5:0]] + w[0];
    t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
       + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        v[i]   <= '0;
        dig[i] <= '0;
      end
      round  <= '0;
      busy   <= 1'b0;
      wptr   <= '0;
      rptr   <= '0;
      text_o <= '0;
    end else if (busy) begin
      if (round != 7'd64) begin
        v[0] <= t1 + t2;
        v[1] <= v[0];
        v[2] <= v[1];
        v[3] <= v[2];
        v[4] <= v[3] + t1;
        v[5] <= v[4];
        v[6] <= v[5];
        v[7] <= v[6];
        for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
        w[15] <= new_w;
        round <= round + 7'd1;
      end else begin
        for (int i = 0; i < 8; i++) dig[i] <= v[i] + IV[i];
        busy <= 1'b0;
      end
    end else if (cmd_w_i) begin
      case (cmd_i)
        3'b001: begin
          w[wptr] <= text_i;
          wptr    <= wptr + 4'd1;
        end
        3'b010: begin
          for (int i = 0; i < 8; i++) v[i] <= IV[i];
          round <= '0;
          busy  <= 1'b1;
          wptr  <= '0;
          rptr  <= '0;
        end
        3'b100: begin
          text_o <= dig[rptr];
          rptr   <= rptr + 3'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

module uart_sha256_top #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int MSG_BYTES    = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic uart_rxd,
  output logic uart_txd
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WRITE = 3'd1, S_START = 3'd2, S_WAIT = 3'd3, S_READ = 3'd4, S_TX = 3'd5
  } state_t;

  rx_state_t     rx_state;
  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte, tx_byte;
  logic          uart_rx_valid;
  logic          tx_busy, tx_done, tx_start;
  logic [9:0]    tx_shift;
  logic [3:0]    tx_bit;
  state_t        state, state_next;
  logic [7:0]    msg [64];
  logic [6:0]    rx_count;
  logic [4:0]    sha_write_cnt;
  logic [3:0]    sha_read_cnt, wk;
  logic [5:0]    tx_count;
  logic [4:0]    tx_idx;
  logic [255:0]  hash_buffer;
  logic          busy_seen, rd_pending;
  logic          sha_cmd_w, sha_busy, unused_cmd;
  logic [2:0]    sha_cmd;
  logic [31:0]   sha_text, sha_text_o;
  logic [3:0]    sha_cmd_o;

  // Core handshake: a command is taken on any cycle with cmd_w_i high while
  // the core is not busy; read data appears on text_o the following cycle.
  sha256 sha256_inst (
    .clk(clk), .reset_n(reset_n), .text_i(sha_text), .cmd_i(sha_cmd),
    .cmd_w_i(sha_cmd_w), .text_o(sha_text_o), .cmd_o(sha_cmd_o)
  );
  assign sha_busy   = sha_cmd_o[3];
  assign unused_cmd = ^sha_cmd_o[2:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_byte       <= '0;
      uart_rx_valid <= 1'b0;
    end else begin
      rx_s1 <= uart_rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      uart_rx_valid <= 1'b0;
      rx_cnt <= rx_cnt + 1'b1;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_s3 && !rx_s2) rx_state <= RX_START;
        end
        RX_START: if (rx_cnt == HALF_BIT) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end
        RX_STOP: if (rx_cnt == BIT_END) begin
          rx_state <= RX_IDLE;
          if (rx_s2) begin
            uart_rx_valid <= 1'b1;
            rx_byte       <= rx_shift;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_shift <= '1;
      tx_bit   <= '0;
      tx_cnt   <= '0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (tx_start) begin
          tx_busy  <= 1'b1;
          tx_shift <= {1'b1, tx_byte, 1'b0};
          tx_cnt   <= '0;
          tx_bit   <= '0;
        end
      end else if (tx_cnt == BIT_END) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          tx_shift <= {1'b1, tx_shift[9:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  assign uart_txd = tx_busy ? tx_shift[0] : 1'b1;
  assign wk       = sha_write_cnt[3:0];
  assign tx_idx   = 5'd31 - tx_count[4:0];
  assign tx_byte  = hash_buffer[{tx_idx, 3'b000} +: 8];

  always_comb begin
    state_next = state;
    sha_cmd_w  = 1'b0;
    sha_cmd    = 3'b000;
    sha_text   = '0;
    tx_start   = 1'b0;
    case (state)
      S_IDLE:  if (uart_rx_valid && rx_count == 7'(MSG_BYTES - 1)) state_next = S_WRITE;
      S_WRITE: begin
        if (sha_write_cnt == 5'd16) state_next = S_START;
        else begin
          sha_cmd_w = 1'b1;
          sha_cmd   = 3'b001;
          sha_text  = {msg[{wk, 2'd0}], msg[{wk, 2'd1}], msg[{wk, 2'd2}], msg[{wk, 2'd3}]};
        end
      end
      S_START: begin
        sha_cmd_w  = 1'b1;
        sha_cmd    = 3'b010;
        state_next = S_WAIT;
      end
      S_WAIT:  if (busy_seen && !sha_busy) state_next = S_READ;
      S_READ: begin
        if (sha_read_cnt == 4'd8) state_next = S_TX;
        else if (!rd_pending) begin
          sha_cmd_w = 1'b1;
          sha_cmd   = 3'b100;
        end
      end
      S_TX: begin
        // tx_done must clear first so tx_count has advanced before the next start.
        if (tx_count == 6'd32) state_next = S_IDLE;
        else if (!tx_busy && !tx_done) tx_start = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      rx_count      <= '0;
      sha_write_cnt <= '0;
      sha_read_cnt  <= '0;
      tx_count      <= '0;
      hash_buffer   <= '0;
      busy_seen     <= 1'b0;
      rd_pending    <= 1'b0;
      for (int i = 0; i < 64; i++) msg[i] <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (uart_rx_valid) begin
          msg[rx_count[5:0]] <= rx_byte;
          rx_count <= rx_count + 7'd1;
        end
        S_WRITE: if (sha_write_cnt != 5'd16) sha_write_cnt <= sha_write_cnt + 5'd1;
        S_START: busy_seen <= 1'b0;
        S_WAIT:  if (sha_busy) busy_seen <= 1'b1;
        S_READ: begin
          if (rd_pending) begin
            hash_buffer  <= {hash_buffer[223:0], sha_text_o};
            sha_read_cnt <= sha_read_cnt + 4'd1;
            rd_pending   <= 1'b0;
          end else if (sha_read_cnt != 4'd8) begin
            rd_pending <= 1'b1;
          end
        end
        S_TX: begin
          if (tx_count == 6'd32) begin
            rx_count      <= '0;
            sha_write_cnt <= '0;
            sha_read_cnt  <= '0;
            tx_count      <= '0;
          end else if (tx_done) begin
            tx_count <= tx_count + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_sha256_top.sv
// Directed bench for uart_sha256_top with a shortened bit time: RX framing,
// digest of two blocks, TX frame decoding, and reset during WAIT and TX.

module tb_uart_sha256_top;
  localparam int CPB = 10;

  localparam logic [0:63][31:0] KT = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [0:7][31:0] IVT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic uart_rxd = 1'b1;
  logic uart_txd;

  uart_sha256_top #(.CLK_FREQ(100), .BAUD(10)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int leave_cyc = -1;
  logic [2:0] prev_state = 3'd0;
  logic busy_hi = 1'b0;
  logic busy_fell = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 compression of one block with the standard IV.
  function automatic logic [255:0] compress(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = IVT;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + IVT[0], b + IVT[1], c + IVT[2], d + IVT[3],
            e + IVT[4], f + IVT[5], g + IVT[6], h + IVT[7]};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Event watcher: valid pulses, idle exit, core busy pulse.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (dut.uart_rx_valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
      end
      if (prev_state == 3'd0 && dut.state != 3'd0 && leave_cyc < 0) leave_cyc = cyc;
      prev_state = dut.state;
      if (dut.sha256_inst.cmd_o[3]) busy_hi = 1'b1;
      else if (busy_hi) busy_fell = 1'b1;
    end
  end

  // TX line decoder feeding got_q.
  initial begin
    logic [7:0] rb;
    forever begin
      @(negedge uart_txd);
      repeat (CPB/2) @(negedge clk);
      if (uart_txd == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rb[i] = uart_txd;
        end
        repeat (CPB) @(negedge clk);
        if (uart_txd) got_q.push_back(rb);
      end
    end
  end

  // Drivers
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_msg(input logic [511:0] blk);
    for (int i = 0; i < 64; i++) send_byte(blk[511 - 8*i -: 8], 1'b1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (dut.state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, dut.state, s);
  endtask

  task automatic wait_tx_done(input string tag);
    int n = 0;
    while (dut.tx_count != 6'd32 && n < 32*10*CPB + 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, dut.tx_count, 32);
  endtask

  // Scoreboard: compare decoded TX bytes against a digest, MSB byte first.
  task automatic score_tx(input logic [255:0] digest, input string tag);
    logic [7:0] g, e;
    check({tag, "_frames"}, got_q.size(), 32);
    for (int k = 0; k < 32; k++) exp_q.push_back(digest[255 - 8*k -: 8]);
    for (int k = 0; k < 32; k++) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      check($sformatf("%s_byte%0d", tag, k), g, e);
    end
    got_q.delete();
  endtask

  initial begin
    logic [511:0] blk1, abc;
    logic [255:0] exp1;
    int v0;

    for (int i = 0; i < 64; i++) blk1[511 - 8*i -: 8] = 8'(i);
    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0] = 32'h00000018;
    exp1 = compress(blk1);

    repeat (10) @(negedge clk);
    check("rst_txd", uart_txd, 1);
    check("rst_state", dut.state, 0);
    check("rst_hash", dut.hash_buffer, 0);
    check("rst_rx_count", dut.rx_count, 0);
    check("rst_write_cnt", dut.sha_write_cnt, 0);
    check("rst_read_cnt", dut.sha_read_cnt, 0);
    check("rst_tx_count", dut.tx_count, 0);
    check("rst_rx_valid", dut.uart_rx_valid, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    v0 = valid_cnt;
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3*CPB) @(negedge clk);
    check("glitch_no_valid", valid_cnt, v0);
    check("glitch_rx_count", dut.rx_count, 0);

    send_byte(8'hA5, 1'b0);
    repeat (CPB) @(negedge clk);
    check("badstop_no_valid", valid_cnt, v0);
    check("badstop_rx_count", dut.rx_count, 0);

    busy_hi = 1'b0;
    busy_fell = 1'b0;
    for (int i = 0; i < 64; i++) begin
      send_byte(8'(i), 1'b1);
      if (i < 63) check($sformatf("rx_count_%0d", i), dut.rx_count, i + 1);
    end
    check("idle_exit_latency",
          (leave_cyc >= last_valid_cyc) && (leave_cyc - last_valid_cyc <= 2), 1);
    wait_state(3'd5, 400, "msg1_reach_tx");
    check("msg1_write_cnt", dut.sha_write_cnt, 16);
    check("msg1_read_cnt", dut.sha_read_cnt, 8);
    check("msg1_busy_pulse", busy_hi && busy_fell, 1);
    check("msg1_hash_nonzero", dut.hash_buffer != 256'd0, 1);
    check("msg1_hash", dut.hash_buffer, exp1);
    wait_tx_done("msg1_tx_count");
    wait_state(3'd0, 4, "msg1_back_idle");
    check("msg1_clr_rx_count", dut.rx_count, 0);
    check("msg1_clr_tx_count", dut.tx_count, 0);
    check("msg1_idle_txd", uart_txd, 1);
    score_tx(exp1, "msg1_tx");

    send_msg(blk1);
    wait_state(3'd3, 100, "msg2_reach_wait");
    reset_n = 1'b0;
    #1;
    check("wait_rst_state", dut.state, 0);
    check("wait_rst_txd", uart_txd, 1);
    check("wait_rst_write_cnt", dut.sha_write_cnt, 0);
    check("wait_rst_hash", dut.hash_buffer, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    send_msg(blk1);
    wait_state(3'd5, 400, "msg3_reach_tx");
    repeat (3*CPB + 3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("tx_rst_state", dut.state, 0);
    check("tx_rst_txd", uart_txd, 1);
    check("tx_rst_tx_count", dut.tx_count, 0);
    check("tx_rst_rx_count", dut.rx_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12*CPB) @(negedge clk);
    got_q.delete();

    send_msg(abc);
    wait_state(3'd5, 400, "abc_reach_tx");
    check("abc_hash", dut.hash_buffer, ABC_DIGEST);
    wait_tx_done("abc_tx_count");
    wait_state(3'd0, 4, "abc_back_idle");
    score_tx(ABC_DIGEST, "abc_tx");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
